// File: rtl/piso_reader.sv
// Parallel-in, serial-out read-out: captures a word on load and drains it LSB first, paced by en.
// Optional even-parity trailer bit is compiled in with `define PISO_READER_PARITY_EN.
module piso_reader #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             en,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             done
);

    // state   | meaning
    // S_IDLE  | ready for a load, outputs quiet
    // S_SHIFT | presenting sreg bit 0, consumed on en
    // S_DONE  | one-cycle done pulse after the last bit

`ifdef PISO_READER_PARITY_EN
    localparam int NBITS = WIDTH + 1;
`else
    localparam int NBITS = WIDTH;
`endif
    localparam int          CW   = $clog2(NBITS + 1);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               done_q, done_d;
    logic [NBITS-1:0]   load_word;

`ifdef PISO_READER_PARITY_EN
    assign load_word = {^din, din};
`else
    assign load_word = din;
`endif

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        cnt_d        = cnt_q;
        ready_d      = ready_q;
        sout_d       = sout_q;
        sout_valid_d = sout_valid_q;
        done_d       = done_q;
        case (state_q)
            S_IDLE: begin
                ready_d      = 1'b1;
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                done_d       = 1'b0;
                if (load) begin
                    sreg_d       = load_word;
                    cnt_d        = '0;
                    state_d      = S_SHIFT;
                    ready_d      = 1'b0;
                    sout_valid_d = 1'b1;
                    sout_d       = load_word[0];
                end
            end
            S_SHIFT: begin
                if (en) begin
                    sreg_d = sreg_q >> 1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        state_d      = S_DONE;
                        sout_d       = 1'b0;
                        sout_valid_d = 1'b0;
                        done_d       = 1'b1;
                    end else begin
                        // next presented bit is the one about to land in bit 0
                        sout_d = sreg_q[1];
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                done_d  = 1'b0;
                ready_d = 1'b1;
            end
            default: begin
                state_d      = S_IDLE;
                ready_d      = 1'b1;
                sout_d       = 1'b0;
                sout_valid_d = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            sreg_q       <= '0;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            sreg_q       <= sreg_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            done_q       <= done_d;
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign done       = done_q;

endmodule

// File: tb/tb_piso_reader.sv
// Directed testbench for piso_reader: table of frames plus hand-written reset sequences.
// Parity frames are checked when PISO_READER_PARITY_EN is defined.
module tb_piso_reader;

    localparam int WIDTH = 8;
`ifdef PISO_READER_PARITY_EN
    localparam int NB = WIDTH + 1;
`else
    localparam int NB = WIDTH;
`endif

    logic             clk;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] din;
    logic             en;
    logic             ready;
    logic             sout;
    logic             sout_valid;
    logic             done;

    int checks = 0;
    int errors = 0;

    piso_reader #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .din        (din),
        .en         (en),
        .ready      (ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp_bits;  // bit i = i-th bit sent
        logic       exp_par;
        int         s1;
        int         s2;
        int         slen;
        bit         ign;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        logic eb;
        int   stall;
        check({nm, " idle_ready"}, 32'(ready), 32'd1);
        load = 1'b1;
        din  = v.din;
        en   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        din  = '0;
        for (int i = 0; i < NB; i++) begin
            eb    = (i < 8) ? v.exp_bits[i] : v.exp_par;
            stall = (i == v.s1 || i == v.s2) ? v.slen : 0;
            for (int j = 0; j < stall; j++) begin
                en = 1'b0;
                check($sformatf("%s stall_sout b%0d", nm, i), 32'(sout), 32'(eb));
                check($sformatf("%s stall_valid b%0d", nm, i), 32'(sout_valid), 32'd1);
                @(negedge clk);
            end
            en = 1'b1;
            check($sformatf("%s sout b%0d", nm, i), 32'(sout), 32'(eb));
            check($sformatf("%s valid b%0d", nm, i), 32'(sout_valid), 32'd1);
            check($sformatf("%s done_low b%0d", nm, i), 32'(done), 32'd0);
            check($sformatf("%s ready_low b%0d", nm, i), 32'(ready), 32'd0);
            if (v.ign && i == 3) begin
                load = 1'b1;
                din  = 8'h00;
            end
            @(negedge clk);
            load = 1'b0;
        end
        check({nm, " done"}, 32'(done), 32'd1);
        check({nm, " done_valid"}, 32'(sout_valid), 32'd0);
        check({nm, " done_sout"}, 32'(sout), 32'd0);
        check({nm, " done_ready"}, 32'(ready), 32'd0);
        if (v.ign) begin
            load = 1'b1;
            din  = 8'h00;
        end
        @(negedge clk);
        load = 1'b0;
        check({nm, " post_ready"}, 32'(ready), 32'd1);
        check({nm, " post_done"}, 32'(done), 32'd0);
        check({nm, " post_valid"}, 32'(sout_valid), 32'd0);
        if (v.ign) begin
            @(negedge clk);
            check({nm, " no_second_frame"}, 32'(sout_valid), 32'd0);
            check({nm, " still_ready"}, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        vecs[0] = '{din: 8'hA5, exp_bits: 8'b1010_0101, exp_par: 1'b0, s1: -1, s2: -1, slen: 0, ign: 1'b0};
        vecs[1] = '{din: 8'h0F, exp_bits: 8'b0000_1111, exp_par: 1'b0, s1: 2,  s2: 5,  slen: 3, ign: 1'b0};
        vecs[2] = '{din: 8'hFF, exp_bits: 8'b1111_1111, exp_par: 1'b0, s1: -1, s2: -1, slen: 0, ign: 1'b1};
        vecs[3] = '{din: 8'h81, exp_bits: 8'b1000_0001, exp_par: 1'b0, s1: 0,  s2: 7,  slen: 1, ign: 1'b0};
        vecs[4] = '{din: 8'h07, exp_bits: 8'b0000_0111, exp_par: 1'b1, s1: -1, s2: -1, slen: 0, ign: 1'b0};

        rst  = 1'b1;
        load = 1'b1;
        din  = 8'hFF;
        en   = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("rst ready c%0d", c), 32'(ready), 32'd1);
            check($sformatf("rst sout c%0d", c), 32'(sout), 32'd0);
            check($sformatf("rst valid c%0d", c), 32'(sout_valid), 32'd0);
            check($sformatf("rst done c%0d", c), 32'(done), 32'd0);
        end
        rst  = 1'b0;
        load = 1'b0;
        din  = '0;
        en   = 1'b0;
        @(negedge clk);
        check("after_rst ready", 32'(ready), 32'd1);
        check("after_rst valid", 32'(sout_valid), 32'd0);

        for (int k = 0; k < 5; k++)
            run_frame(vecs[k], $sformatf("vec%0d", k));

        // mid-frame reset: 3C, reset while bit 4 is presented
        load = 1'b1;
        din  = 8'h3C;
        en   = 1'b1;
        @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("mid sout b%0d", i), 32'(sout), (i >= 2) ? 32'd1 : 32'd0);
            check($sformatf("mid valid b%0d", i), 32'(sout_valid), 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst valid", 32'(sout_valid), 32'd0);
        check("mid_rst ready", 32'(ready), 32'd1);
        check("mid_rst done", 32'(done), 32'd0);
        check("mid_rst sout", 32'(sout), 32'd0);
        @(negedge clk);
        check("mid_rst no_done", 32'(done), 32'd0);
        check("mid_rst idle_valid", 32'(sout_valid), 32'd0);

        run_frame(vecs[0], "recover");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
